// File: rtl/pipelined_bit_reducer_pkg.sv
// Shared definitions for the pipelined bit reducer: operator encodings and
// the per-slice reduction helpers used by every pipeline stage.
package pipelined_bit_reducer_pkg;

   localparam logic [1:0] MODE_AND  = 2'b00;
   localparam logic [1:0] MODE_OR   = 2'b01;
   localparam logic [1:0] MODE_XOR  = 2'b10;
   localparam logic [1:0] MODE_NAND = 2'b11;

   // Widest slice a single stage may reduce; callers fill unused bits with
   // the operator identity so they do not disturb the result.
   localparam int SLICE_MAX = 64;

   // Neutral element of the core operator (AND family -> 1, OR/XOR -> 0).
   function automatic logic identity_of(input logic [1:0] mode);
      return (mode == MODE_AND) || (mode == MODE_NAND);
   endfunction

   // Fold one identity-padded slice into the running accumulator.
   // NAND uses the AND core; its inversion is applied once at the output.
   function automatic logic slice_reduce(input logic                 acc,
                                         input logic [SLICE_MAX-1:0] slice,
                                         input logic [1:0]           mode);
      logic r;
      case (mode)
         MODE_OR:  r = acc | (|slice);
         MODE_XOR: r = acc ^ (^slice);
         default:  r = acc & (&slice);
      endcase
      return r;
   endfunction

   function automatic int stages_of(input int n, input int k);
      return (n + k - 1) / k;
   endfunction

endpackage

// File: rtl/pipelined_bit_reducer_reduce_stage.sv
// One register stage of the reducer: folds slice IDX of the (padded) word
// into the accumulator and holds everything while downstream stalls.
module reduce_stage
   import pipelined_bit_reducer_pkg::*;
#(
   parameter int NP    = 16,
   parameter int K     = 4,
   parameter int TAG_W = 4,
   parameter int IDX   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [1:0]       up_mode,
   input  logic [TAG_W-1:0] up_tag,
   input  logic             up_acc,
   input  logic [NP-1:0]    up_data,
   input  logic             dn_ready,
   output logic             valid,
   output logic [1:0]       mode,
   output logic [TAG_W-1:0] tag,
   output logic             acc,
   output logic [NP-1:0]    data
);

   logic [SLICE_MAX-1:0] slice_w;
   logic                 next_acc;

   // An empty stage always accepts, so bubbles collapse toward the output.
   assign up_ready = !valid || dn_ready;

   // Widen this stage's slice with identity bits and fold it into acc.
   always_comb begin
      slice_w          = {SLICE_MAX{identity_of(up_mode)}};
      slice_w[K-1:0]   = up_data[IDX*K +: K];
      next_acc         = slice_reduce(up_acc, slice_w, up_mode);
   end

   // Stage register: load on advance, otherwise hold contents stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         mode  <= 2'b00;
         tag   <= '0;
         acc   <= 1'b0;
         data  <= '0;
      end else if (up_ready) begin
         valid <= up_valid;
         if (up_valid) begin
            mode <= up_mode;
            tag  <= up_tag;
            acc  <= next_acc;
            data <= up_data;
         end
      end
   end

endmodule

// File: rtl/pipelined_bit_reducer.sv
// Pipelined N-bit to 1-bit reducer (AND/OR/XOR/NAND) with valid/ready
// handshake and sideband tag. This level only chains the stages, pads the
// top slice and applies the final NAND inversion.
module pipelined_bit_reducer
   import pipelined_bit_reducer_pkg::*;
#(
   parameter int N     = 16,
   parameter int K     = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int STAGES = stages_of(N, K);
   localparam int NP     = STAGES * K;

   logic [STAGES:0]  v_c;
   logic [STAGES:0]  r_c;
   logic [STAGES:0]  a_c;
   logic [1:0]       m_c [STAGES+1];
   logic [TAG_W-1:0] t_c [STAGES+1];
   logic [NP-1:0]    d_c [STAGES+1];
   logic             unused_data;

   assign v_c[0] = in_valid;
   assign m_c[0] = in_mode;
   assign t_c[0] = in_tag;
   assign a_c[0] = identity_of(in_mode);

   // Fill the top slice with the identity so padding never changes the result.
   if (NP > N) begin : g_pad
      assign d_c[0] = {{(NP-N){a_c[0]}}, in_data};
   end else begin : g_nopad
      assign d_c[0] = in_data;
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      reduce_stage #(
         .NP    (NP),
         .K     (K),
         .TAG_W (TAG_W),
         .IDX   (s)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .up_valid (v_c[s]),
         .up_ready (r_c[s]),
         .up_mode  (m_c[s]),
         .up_tag   (t_c[s]),
         .up_acc   (a_c[s]),
         .up_data  (d_c[s]),
         .dn_ready (r_c[s+1]),
         .valid    (v_c[s+1]),
         .mode     (m_c[s+1]),
         .tag      (t_c[s+1]),
         .acc      (a_c[s+1]),
         .data     (d_c[s+1])
      );
   end

   assign r_c[STAGES] = out_ready;
   assign in_ready    = r_c[0];
   assign out_valid   = v_c[STAGES];
   assign out_tag     = t_c[STAGES];
   assign busy        = |v_c[STAGES:1];
   assign out_bit     = (m_c[STAGES] == MODE_NAND) ? ~a_c[STAGES] : a_c[STAGES];

   // The last stage's word copy has no consumer.
   assign unused_data = ^d_c[STAGES];

endmodule

// File: tb/tb_pipelined_bit_reducer.sv
module tb_pipelined_bit_reducer;
   import pipelined_bit_reducer_pkg::*;

   localparam int N   = 16;
   localparam int K   = 4;
   localparam int TW  = 4;
   localparam int ST  = 4;
   localparam int NB  = 10;
   localparam int STB = 3;
   localparam int NT  = 9;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          in_valid, in_ready, out_valid, out_ready, out_bit, busy;
   logic [N-1:0]  in_data;
   logic [1:0]    in_mode;
   logic [TW-1:0] in_tag, out_tag;

   logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_bit, b_busy;
   logic [NB-1:0] b_in_data;
   logic [1:0]    b_in_mode;
   logic [TW-1:0] b_in_tag, b_out_tag;

   pipelined_bit_reducer #(.N(N), .K(K), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
      .out_tag(out_tag), .busy(busy));

   pipelined_bit_reducer #(.N(NB), .K(K), .TAG_W(TW)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_mode(b_in_mode), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bit(b_out_bit),
      .out_tag(b_out_tag), .busy(b_busy));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: count ones over the n valid bits and apply the operator rule.
   function automatic logic ref_reduce(input logic [31:0] d, input logic [1:0] m, input int n);
      int ones;
      ones = 0;
      for (int i = 0; i < n; i++) ones += int'(d[i]);
      case (m)
         2'b00:   return ones == n;
         2'b01:   return ones != 0;
         2'b10:   return (ones % 2) == 1;
         default: return ones != n;
      endcase
   endfunction

   typedef struct {
      logic          b;
      logic [TW-1:0] tag;
      int            cyc;
   } rec_t;

   typedef struct {
      logic [N-1:0]  d;
      logic [1:0]    m;
      logic [TW-1:0] t;
      logic          b;
   } vec_t;

   rec_t          exp_q[$];
   rec_t          obs_q[$];
   int            cyc = 0;
   logic          acc_flag = 1'b0;
   int            acc_cnt = 0;
   logic          chk_lat = 1'b0;
   logic          prev_stall = 1'b0;
   logic          prev_bit = 1'b0;
   logic [TW-1:0] prev_tag = '0;

   // Scoreboard: samples just before each rising edge.
   always begin
      rec_t e;
      @(negedge clk);
      #4;
      cyc++;
      acc_flag = 1'b0;
      if (!rst_n) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_bit", 32'(out_bit), 32'(prev_bit));
            chk("hold_tag", 32'(out_tag), 32'(prev_tag));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("out_bit", 32'(out_bit), 32'(e.b));
               chk("out_tag", 32'(out_tag), 32'(e.tag));
               if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'(ST));
            end
            obs_q.push_back('{out_bit, out_tag, cyc});
         end
         if (in_valid && in_ready) begin
            exp_q.push_back('{ref_reduce(32'(in_data), in_mode, N), in_tag, cyc});
            acc_flag = 1'b1;
            acc_cnt++;
         end
         prev_stall = out_valid && !out_ready;
         prev_bit   = out_bit;
         prev_tag   = out_tag;
      end
   end

   // Present a word and wait (bounded) until it is accepted; leaves in_valid high.
   task automatic send(input logic [N-1:0] d, input logic [1:0] m, input logic [TW-1:0] t);
      int w;
      w = 0;
      in_data  = d;
      in_mode  = m;
      in_tag   = t;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         w++;
      end while (!acc_flag && w < 50);
      if (!acc_flag) chk("send_timeout", 32'(acc_flag), 32'd1);
   endtask

   task automatic drain();
      int w;
      w = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || busy) && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      chk("drain_busy", 32'(busy), 32'd0);
   endtask

   // One word through the N=10 instance, checking exact 3-cycle latency.
   task automatic b_run(input logic [NB-1:0] d, input logic [1:0] m, input logic [TW-1:0] t);
      b_in_data  = d;
      b_in_mode  = m;
      b_in_tag   = t;
      b_in_valid = 1'b1;
      #4;
      chk("b_in_ready", 32'(b_in_ready), 32'd1);
      @(negedge clk);
      b_in_valid = 1'b0;
      for (int i = 1; i <= STB; i++) begin
         #4;
         chk("b_out_valid", 32'(b_out_valid), 32'(i == STB));
         if (i == STB) begin
            chk("b_out_bit", 32'(b_out_bit), 32'(ref_reduce(32'(d), m, NB)));
            chk("b_out_tag", 32'(b_out_tag), 32'(t));
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[NT];
      tbl[0] = '{16'hFFFF, MODE_AND,  4'd3, 1'b1};
      tbl[1] = '{16'hFFFE, MODE_AND,  4'd6, 1'b0};
      tbl[2] = '{16'h0000, MODE_OR,   4'd0, 1'b0};
      tbl[3] = '{16'h0100, MODE_OR,   4'd1, 1'b1};
      tbl[4] = '{16'h0007, MODE_XOR,  4'd2, 1'b1};
      tbl[5] = '{16'h0003, MODE_XOR,  4'd3, 1'b0};
      tbl[6] = '{16'hFFFF, MODE_NAND, 4'd4, 1'b0};
      tbl[7] = '{16'h0000, MODE_NAND, 4'd5, 1'b1};
      tbl[8] = '{16'h8000, MODE_AND,  4'd7, 1'b0};

      in_valid = 1'b0; in_data = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_in_tag = '0; b_out_ready = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_bit", 32'(out_bit), 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // Directed table, streamed back to back with latency checks.
      obs_q.delete();
      chk_lat = 1'b1;
      for (int i = 0; i < NT; i++) send(tbl[i].d, tbl[i].m, tbl[i].t);
      drain();
      chk_lat = 1'b0;
      chk("tbl_count", 32'(obs_q.size()), 32'(NT));
      for (int i = 0; i < NT; i++) begin
         if (i < obs_q.size()) begin
            chk("tbl_bit", 32'(obs_q[i].b), 32'(tbl[i].b));
            chk("tbl_tag", 32'(obs_q[i].tag), 32'(tbl[i].t));
            if (i > 0) chk("tbl_consecutive", 32'(obs_q[i].cyc - obs_q[i-1].cyc), 32'd1);
         end
      end

      // Backpressure: only STAGES words fit while the output is blocked.
      out_ready = 1'b0;
      acc_cnt = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = 16'($urandom);
         in_mode = 2'(i);
         in_tag  = 4'(i);
         @(negedge clk);
      end
      chk("bp_accepted", 32'(acc_cnt), 32'd4);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      drain();

      // Bubble collapse: gaps at the input never block while slots are free.
      out_ready = 1'b0;
      acc_cnt = 0;
      send(16'h1234, MODE_XOR, 4'd9);
      in_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("bubble_ready", 32'(in_ready), 32'd1);
         send(16'($urandom), 2'(j), 4'(10 + j));
         in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bubble_count", 32'(acc_cnt), 32'd4);
      chk("bubble_full", 32'(in_ready), 32'd0);
      drain();

      // Random traffic with random stalls against the reference.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 16'($urandom);
         in_mode   = 2'($urandom_range(0, 3));
         in_tag    = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      drain();

      // Asynchronous reset with words in flight.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(16'hFFFF, MODE_AND, 4'(i));
      in_valid = 1'b0;
      @(negedge clk);
      chk("inflight_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      send(16'h0001, MODE_OR, 4'd15);
      drain();

      // Uneven width instance: N=10, K=4, three stages.
      b_run(10'h3FF, MODE_AND, 4'd1);
      b_run(10'h200, MODE_XOR, 4'd2);
      b_run(10'h3FF, MODE_NAND, 4'd3);
      b_run(10'h1FF, MODE_AND, 4'd4);
      b_run(10'h000, MODE_OR, 4'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_bit_reducer.md
Name: pipelined_bit_reducer

Overview:
- Parametrised, pipelined successor to the single-op combinational AND-reduce chain.
- Reduces an N-bit word to one bit with a runtime-selectable operator: AND, OR, XOR or NAND.
- The reduction is split into K-bit slices, one register stage per slice, with a valid/ready handshake and a sideband tag.
- Sits between operand producers and the datapath's condition/flag logic, where a long reduce chain limits Fmax.

Parameters:
- N, 16, input word width (>=1).
- K, 4, bits reduced per pipeline stage (1..N); STAGES = ceil(N/K).
- TAG_W, 4, width of the sideband tag carried alongside each word.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  N  word to reduce.
- in_mode  in  2  operator: 00 AND, 01 OR, 10 XOR, 11 NAND.
- in_tag  in  TAG_W  sideband; returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_bit  out  1  reduction result.
- out_tag  out  TAG_W  tag of the word producing out_bit.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n; all registers clear immediately on assertion.
- Reset values:
  - every stage valid = 0, so out_valid = 0 and busy = 0.
  - out_bit = 0, out_tag = 0, every internal accumulator = 0.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Pipeline: stages 0..STAGES-1, each holding valid, mode, tag, acc and the unreduced upper bits.
- Stage s combines acc with slice in_data[s*K +: K]:
  - Stage 0 starts from the operator identity: 1 for AND/NAND, 0 for OR/XOR.
  - The core op is AND for AND/NAND, OR for OR, XOR for XOR.
  - NAND inverts only in the last stage.
- Width rule: if N is not a multiple of K, the top slice is padded with the identity value. The result must equal the plain reduction of all N bits.
- Latency: a word accepted in cycle t presents out_valid in cycle t+STAGES when no stall occurs. Throughput is one word per cycle.
- Per-stage ready (bubble-collapsing):
  - ready[s] = !valid[s] || ready[s+1].
  - ready[STAGES] = out_ready.
  - in_ready = ready[0], which is combinational from out_ready and the valid bits.
- A stalled stage holds acc, mode, tag and data stable.
- Upstream empty stages keep accepting words until they fill, so an empty slot never blocks the input.
- Output stability: while out_valid && !out_ready, out_bit and out_tag hold.
- Mode is captured per word at input transfer. Changing in_mode mid-flight does not affect words already accepted.
- Simultaneous accept and emit: legal every cycle, with no loss and no duplication.
- Reset mid-operation: all in-flight words are discarded and no partial result is emitted after release.
- After reset release, in_ready = 1 in the first cycle.
- Degenerate case K >= N: STAGES = 1 and latency = 1.
- Ordering: results leave strictly in input order.

Decomposition:
- Package pipelined_bit_reducer_pkg holds:
  - mode encodings MODE_AND/MODE_OR/MODE_XOR/MODE_NAND.
  - function identity_of(mode).
  - function slice_reduce(acc, slice, mode).
  - function stages_of(N, K) returning ceil(N/K).
- Sub-module reduce_stage holds one register stage (valid/ready, acc, tag, mode, residual data). Instantiate it STAGES times with a generate loop. The top level is stage chaining and output invert only.

Test Plan:
- N=16, K=4, mode AND, 0xFFFF, tag 3, out_ready=1 -> out_valid exactly 4 cycles later; out_bit=1, out_tag=3. Then 0xFFFE -> out_bit=0.
- Back-to-back stream, modes OR/XOR/NAND: 0x0000 OR -> 0; 0x0100 OR -> 1; 0x0007 XOR -> 1; 0x0003 XOR -> 0; 0xFFFF NAND -> 0. Results arrive on 5 consecutive cycles in order, tags 0..4 preserved.
- Backpressure: hold out_ready=0 while streaming -> exactly 4 words accepted, then in_ready=0. out_bit/out_tag are stable. Raising out_ready drains all 4 in order with no loss or duplicate.
- Bubble collapse: accept one word, stall the output 3 cycles with gaps at the input -> the pipeline fills to 4 words without in_ready dropping early.
- Uneven width N=10, K=4 (STAGES=3): AND of 0x3FF -> 1 after 3 cycles. XOR of 0x200 -> 1, checking that padding does not corrupt the result.
- Assert rst_n low asynchronously with 3 words in flight -> out_valid and busy drop immediately with no clock. After release, nothing is emitted until a new word enters; in_ready=1.
